// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory port.
// Requester 0 is the core load/store path and requester 1 is the loader/debug DMA.
// Each access is held on the memory port for MEM_LAT cycles.
// Completion is signalled with a one-cycle rvalid pulse to the requester that was granted.
module dmem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data
);

    // state | meaning
    // IDLE  | memory port free; requests are sampled on every edge
    // BUSY  | latched access driven onto the memory port; cnt_q counts down to completion
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             last_q;
    logic             id_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             start;
    logic             start_id;
    logic             done;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arbitrate in IDLE, finish in BUSY once the counter reaches zero.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        start_id = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    start   = 1'b1;
                    state_d = BUSY;
                    // On contention the requester that did not win last time takes the port.
                    start_id = (m0_req && m1_req) ? ~last_q : m1_req;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Access latch, latency counter, grant/response pulses and read data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_gnt    <= start & ~start_id;
            m1_gnt    <= start & start_id;
            m0_rvalid <= done & ~id_q;
            m1_rvalid <= done & id_q;
            if (start) begin
                id_q    <= start_id;
                last_q  <= start_id;
                we_q    <= start_id ? m1_we    : m0_we;
                addr_q  <= start_id ? m1_addr  : m0_addr;
                wdata_q <= start_id ? m1_wdata : m0_wdata;
                cnt_q   <= LAT_LOAD;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done && !we_q) begin
                if (id_q) begin
                    m1_rdata <= mem_read_data;
                end else begin
                    m0_rdata <= mem_read_data;
                end
            end
        end
    end

    // Memory port decode; enables follow the state register so reset drops them at once.
    always_comb begin
        mem_read_en    = (state_q == BUSY) & ~we_q;
        mem_write_en   = (state_q == BUSY) & we_q;
        mem_addr       = addr_q;
        mem_write_data = wdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
// Two instances are built: u_dut_a uses MEM_LAT=1 and u_dut_b uses MEM_LAT=3. They share the requester stimulus.
// Each instance has its own small word memory. sel chooses which instance's outputs are observed.
module tb_dmem_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         m0_req, m0_we, m1_req, m1_we;
    logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic         a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_rd_en, a_wr_en;
    logic [W-1:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata, a_mrd;
    logic         b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_rd_en, b_wr_en;
    logic [W-1:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata, b_mrd;

    dmem_arbiter #(.WIDTH(W), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_read_en(a_rd_en), .mem_write_en(a_wr_en), .mem_addr(a_addr),
        .mem_write_data(a_wdata), .mem_read_data(a_mrd)
    );

    dmem_arbiter #(.WIDTH(W), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_read_en(b_rd_en), .mem_write_en(b_wr_en), .mem_addr(b_addr),
        .mem_write_data(b_wdata), .mem_read_data(b_mrd)
    );

    // Word memories behind each arbiter; the ld_* port preloads both.
    logic [W-1:0] mem_a [32];
    logic [W-1:0] mem_b [32];
    logic         ld_en = 1'b0;
    logic [4:0]   ld_idx = '0;
    logic [W-1:0] ld_val = '0;

    assign a_mrd = mem_a[a_addr[6:2]];
    assign b_mrd = mem_b[b_addr[6:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem_a[ld_idx] = ld_val;
            mem_b[ld_idx] = ld_val;
        end else begin
            if (a_wr_en) mem_a[a_addr[6:2]] = a_wdata;
            if (b_wr_en) mem_b[b_addr[6:2]] = b_wdata;
        end
    end

    // Observation bundle: {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read_en, mem_write_en}.
    logic         sel = 1'b0;
    logic [5:0]   o_ctl;
    logic [W-1:0] o_addr, o_wdata, o_rdata0, o_rdata1;
    assign o_ctl    = sel ? {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_rd_en, b_wr_en}
                          : {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_rd_en, a_wr_en};
    assign o_addr   = sel ? b_addr : a_addr;
    assign o_wdata  = sel ? b_wdata : a_wdata;
    assign o_rdata0 = sel ? b_m0_rdata : a_m0_rdata;
    assign o_rdata1 = sel ? b_m1_rdata : a_m1_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drop_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load_word(input int idx, input logic [W-1:0] val);
        ld_en  = 1'b1;
        ld_idx = idx[4:0];
        ld_val = val;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        n_tests++;
        if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_rd_en, a_wr_en, a_addr, a_wdata, a_m0_rdata, a_m1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: ctl=%b addr=%h wdata=%h rd0=%h rd1=%h required all zero",
                     {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_rd_en, a_wr_en}, a_addr, a_wdata, a_m0_rdata, a_m1_rdata);
        end
        n_tests++;
        if ({b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_rd_en, b_wr_en, b_addr, b_wdata, b_m0_rdata, b_m1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: ctl=%b addr=%h wdata=%h rd0=%h rd1=%h required all zero",
                     {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_rd_en, b_wr_en}, b_addr, b_wdata, b_m0_rdata, b_m1_rdata);
        end
    endtask

    task automatic test_single_read();
        sel = 1'b0;
        apply_reset();
        load_word(4, 32'hDEADBEEF);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = $urandom;
        step();
        n_tests++;
        if (o_ctl !== 6'b100010 || o_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL read_grant: ctl=%b addr=%h required ctl=100010 addr=00000010", o_ctl, o_addr);
        end
        m0_req = 1'b0;
        step();
        n_tests++;
        if (o_ctl !== 6'b001000 || o_rdata0 !== 32'hDEADBEEF || o_rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL read_done: ctl=%b rd0=%h rd1=%h required ctl=001000 rd0=deadbeef rd1=0", o_ctl, o_rdata0, o_rdata1);
        end
        step();
        n_tests++;
        if (o_ctl !== 6'b000000) begin
            n_fail++;
            $display("FAIL read_idle: ctl=%b required 000000", o_ctl);
        end
    endtask

    task automatic test_single_write();
        sel = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        step();
        n_tests++;
        if (o_ctl !== 6'b010001 || o_addr !== 32'h20 || o_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_grant: ctl=%b addr=%h wdata=%h required ctl=010001 addr=00000020 wdata=12345678",
                     o_ctl, o_addr, o_wdata);
        end
        m1_req = 1'b0;
        step();
        n_tests++;
        if (o_ctl !== 6'b000100 || o_rdata1 !== 32'h0 || o_rdata0 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_done: ctl=%b rd1=%h rd0=%h required ctl=000100 rd1=0 rd0=deadbeef", o_ctl, o_rdata1, o_rdata0);
        end
    endtask

    task automatic test_contention();
        logic [5:0] exp;
        sel = 1'b0;
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) exp = (((k - 1) / 2) % 2 == 0) ? 6'b100010 : 6'b010010;
            else            exp = (((k - 2) / 2) % 2 == 0) ? 6'b001000 : 6'b000100;
            n_tests++;
            if (o_ctl !== exp) begin
                n_fail++;
                $display("FAIL contention cycle %0d: ctl=%b required %b", k, o_ctl, exp);
            end
        end
        drop_reqs();
        step();
        step();
    endtask

    task automatic test_lat3();
        logic [5:0]   exp [8];
        logic [W-1:0] v0, v1;
        exp = '{6'b100010, 6'b000010, 6'b000010, 6'b001000, 6'b010010, 6'b000010, 6'b000010, 6'b000100};
        sel = 1'b1;
        apply_reset();
        v0 = $urandom;
        v1 = $urandom;
        load_word(16, v0);
        load_word(17, v1);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_tests++;
            if (o_ctl !== exp[k-1]) begin
                n_fail++;
                $display("FAIL lat3 cycle %0d: ctl=%b required %b", k, o_ctl, exp[k-1]);
            end
            if (k == 1) begin
                m0_req = 1'b0;
                m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
            end
            if (k == 5) m1_req = 1'b0;
        end
        n_tests++;
        if (o_rdata0 !== v0 || o_rdata1 !== v1) begin
            n_fail++;
            $display("FAIL lat3_data: rd0=%h rd1=%h required rd0=%h rd1=%h", o_rdata0, o_rdata1, v0, v1);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        step();
        m0_req = 1'b0;
        step();
        n_tests++;
        if (o_ctl !== 6'b000010) begin
            n_fail++;
            $display("FAIL midrst_busy: ctl=%b required 000010", o_ctl);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({o_ctl, o_addr, o_wdata, o_rdata0, o_rdata1} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: ctl=%b addr=%h wdata=%h rd0=%h rd1=%h required all zero",
                     o_ctl, o_addr, o_wdata, o_rdata0, o_rdata1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (o_ctl !== 6'b000000) begin
                n_fail++;
                $display("FAIL midrst_quiet cycle %0d: ctl=%b required 000000", k, o_ctl);
            end
        end
        m0_req = 1'b1; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        step();
        n_tests++;
        if (o_ctl !== 6'b100010) begin
            n_fail++;
            $display("FAIL midrst_order: ctl=%b required 100010", o_ctl);
        end
        drop_reqs();
        repeat (4) step();
    endtask

    // Transaction-level reference: the port is free from a given cycle onward,
    // each grant occupies it for lat cycles plus one idle sampling cycle, and the memory is a plain array.
    task automatic test_random(input logic which, input int lat, input int ncyc);
        logic [W-1:0] mdl_mem [32];
        logic [W-1:0] exp_rd [2];
        logic         req [2];
        logic         we [2];
        logic [W-1:0] addr [2];
        logic [W-1:0] wdata [2];
        logic         s_req [2];
        logic         s_we [2];
        logic [W-1:0] s_addr [2];
        logic [W-1:0] s_wdata [2];
        logic [W-1:0] cur_addr, cur_wdata;
        logic         cur_we, cur_id, last_id, busy, id;
        logic [1:0]   eg, er;
        logic [5:0]   exp_ctl;
        int           done_at;
        sel = which;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i] = $urandom;
            load_word(i, mdl_mem[i]);
        end
        exp_rd[0] = '0; exp_rd[1] = '0;
        cur_addr = '0; cur_wdata = '0; cur_we = 1'b0; cur_id = 1'b0;
        last_id = 1'b1; busy = 1'b0; done_at = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        for (int n = 1; n <= ncyc; n++) begin
            for (int i = 0; i < 2; i++) begin
                s_req[i] = req[i]; s_we[i] = we[i]; s_addr[i] = addr[i]; s_wdata[i] = wdata[i];
            end
            step();
            eg = 2'b00;
            er = 2'b00;
            if (busy) begin
                if (n == done_at) begin
                    er[cur_id] = 1'b1;
                    if (cur_we) mdl_mem[cur_addr[6:2]] = cur_wdata;
                    else        exp_rd[cur_id] = mdl_mem[cur_addr[6:2]];
                    busy = 1'b0;
                end
            end else if (s_req[0] || s_req[1]) begin
                id = (s_req[0] && s_req[1]) ? ~last_id : s_req[1];
                last_id = id;
                cur_id = id; cur_we = s_we[id]; cur_addr = s_addr[id]; cur_wdata = s_wdata[id];
                busy = 1'b1;
                done_at = n + lat;
                eg[id] = 1'b1;
            end
            exp_ctl = {eg[0], eg[1], er[0], er[1], busy & ~cur_we, busy & cur_we};
            n_tests++;
            if (o_ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl lat=%0d cycle %0d: ctl=%b required %b", lat, n, o_ctl, exp_ctl);
            end
            n_tests++;
            if (o_addr !== cur_addr || o_wdata !== cur_wdata) begin
                n_fail++;
                $display("FAIL rand_port lat=%0d cycle %0d: addr=%h wdata=%h required addr=%h wdata=%h",
                         lat, n, o_addr, o_wdata, cur_addr, cur_wdata);
            end
            n_tests++;
            if (o_rdata0 !== exp_rd[0] || o_rdata1 !== exp_rd[1]) begin
                n_fail++;
                $display("FAIL rand_rdata lat=%0d cycle %0d: rd0=%h rd1=%h required rd0=%h rd1=%h",
                         lat, n, o_rdata0, o_rdata1, exp_rd[0], exp_rd[1]);
            end
            for (int i = 0; i < 2; i++) begin
                if (req[i] && eg[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && n < ncyc - 20 && $urandom_range(0, 2) == 0) begin
                    req[i]   = 1'b1;
                    we[i]    = $urandom_range(0, 1) == 1;
                    addr[i]  = 32'($urandom_range(0, 31)) << 2;
                    wdata[i] = $urandom;
                end
            end
            m0_req = req[0]; m0_we = we[0]; m0_addr = addr[0]; m0_wdata = wdata[0];
            m1_req = req[1]; m1_we = we[1]; m1_addr = addr[1]; m1_wdata = wdata[1];
        end
    endtask

    initial begin
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lat3();
        test_reset_mid();
        test_random(1'b0, 1, 400);
        test_random(1'b1, 3, 400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer for the shared data memory (dmu_engine) in the RISC-V design. It shares the single memory port between requester 0 (core load/store path) and requester 1 (program loader / debug DMA). It uses round-robin arbitration and a req/gnt/rvalid handshake. Each granted access is held on the memory port for a fixed, parameterised latency, then completed with a response pulse.

Parameters:
WIDTH, 32, data and address width in bits
MEM_LAT, 1, cycles mem_* enables are held per access before read data is sampled (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
m0_req  input  1  requester 0 access request
m0_we  input  1  requester 0 write (1) / read (0)
m0_addr  input  WIDTH  requester 0 byte address
m0_wdata  input  WIDTH  requester 0 write data
m0_gnt  output  1  requester 0 grant pulse
m0_rvalid  output  1  requester 0 completion pulse
m0_rdata  output  WIDTH  requester 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for requester 1
mem_read_en  output  1  to dmu_engine read_en
mem_write_en  output  1  to dmu_engine write_en
mem_addr  output  WIDTH  to dmu_engine addr
mem_write_data  output  WIDTH  to dmu_engine write_data
mem_read_data  input  WIDTH  from dmu_engine out_data

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-low.
- Reset, while rst=0:
  - all outputs 0; state IDLE; latency counter 0.
  - round-robin pointer last=1, so m0 wins the first contention.
- States: IDLE and BUSY.
- IDLE, on an edge where m0_req or m1_req is sampled high:
  - Select the requester. If only one requests, take it. If both request, take the one != last.
  - Latch that requester's we/addr/wdata and its id; set last=id.
  - Load counter=MEM_LAT-1 and go to BUSY.
  - Registered mX_gnt=1 for exactly the first BUSY cycle.
- BUSY outputs:
  - mem_read_en = ~we_latched; mem_write_en = we_latched.
  - mem_addr and mem_write_data come from the latched values.
  - Both enables are 0 in IDLE.
  - mem_addr and mem_write_data hold their last latched value in IDLE (0 after reset).
- BUSY with counter != 0: decrement the counter.
- BUSY with counter == 0, on the edge:
  - For reads: mX_rdata <= mem_read_data.
  - For both reads and writes: mX_rvalid=1 for one cycle.
  - Go to IDLE.
- mX_rdata holds its value until the next read completion for that requester. Writes never change rdata.
- Latency and throughput:
  - req sampled at edge E; gnt high in cycle E..E+1.
  - Memory enables high for MEM_LAT cycles.
  - rvalid high in the cycle after edge E+MEM_LAT.
  - Back-to-back throughput is one access per MEM_LAT+1 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Fields may change after gnt.
  - Drop req in the cycle gnt is seen. A req still high when the arbiter returns to IDLE is treated as a new request.
- Requests arriving during BUSY are not sampled. They wait, with no loss, until IDLE.
- Never more than one outstanding access. Never both mem_read_en and mem_write_en high. Never gnt to both requesters.
- Reset asserted mid-access: the transaction is aborted, enables drop immediately (asynchronously), no rvalid is issued, pointer returns to last=1.
- Arithmetic: none on data; the counter is 4 bits and saturates at no value (it only loads and decrements).

Test Plan:
1. Single read, MEM_LAT=1: m0_req, we=0, addr=0x10, memory returns 0xDEADBEEF.
   -> m0_gnt 1 cycle; mem_read_en high 1 cycle with mem_addr=0x10; next cycle m0_rvalid=1 and m0_rdata=0xDEADBEEF; m1_* stay 0.
2. Single write: m1_req, we=1, addr=0x20, wdata=0x12345678.
   -> mem_write_en 1 cycle with mem_addr=0x20 and mem_write_data=0x12345678; m1_rvalid pulse; m1_rdata unchanged.
3. Contention: m0 and m1 request on the same edge after reset, both held high.
   -> grant order m0, m1, m0, m1; each access spaced 2 cycles apart at MEM_LAT=1; gnt never simultaneous.
4. MEM_LAT=3 read at addr 0x40.
   -> mem_read_en high exactly 3 cycles; rvalid the cycle after; a m1_req raised during BUSY is granted on the edge after return to IDLE.
5. Reset mid-access: assert rst=0 during the second BUSY cycle of a MEM_LAT=3 read.
   -> all outputs 0 immediately; no rvalid after release; next contention grants m0 first.
